// File: rtl/mem_io_responder.sv
// Memory-side responder for the CPU memread/memwrite bus: word RAM plus an I/O page holding
// an input-event FIFO and a free-running tick counter. Read data is returned one cycle later.
module mem_io_responder #(
  parameter int unsigned RAM_DEPTH  = 1024,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        rvalid,
  input  logic        evt_valid,
  input  logic [7:0]  evt_data,
  output logic        evt_ready,
  output logic        tick_flag
);

  localparam int unsigned RamAw  = $clog2(RAM_DEPTH);
  localparam int unsigned FifoAw = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW   = FifoAw + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(FIFO_DEPTH);

  localparam logic [15:0] AddrEvt    = 16'hFF00;
  localparam logic [15:0] AddrStatus = 16'hFF01;
  localparam logic [15:0] AddrTick   = 16'hFF02;
  localparam logic [15:0] AddrClr    = 16'hFF03;

  typedef enum logic [0:0] {StIdle, StResp} state_e;

  state_e state_q, state_d;

  logic        rd_req, wr_req;
  logic [15:0] rd_val, rdata_q;

  // A simultaneous read and write performs only the write.
  assign rd_req = memread && !memwrite;
  assign wr_req = memwrite;

  // Word RAM, not reset.
  logic [15:0] ram_q [RAM_DEPTH];

  always_ff @(posedge clk) begin
    if (wr_req && !addr[15]) begin
      ram_q[addr[RamAw-1:0]] <= wdata;
    end
  end

  // Event FIFO
  logic [7:0]        fifo_q [FIFO_DEPTH];
  logic [FifoAw-1:0] wptr_q, rptr_q;
  logic [CntW-1:0]   count_q;
  logic              full, empty, push, pop;

  assign full      = (count_q == FullCnt);
  assign empty     = (count_q == '0);
  assign evt_ready = !full && !reset;
  assign push      = evt_valid && evt_ready;
  assign pop       = rd_req && (addr == AddrEvt) && !empty;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wptr_q] <= evt_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + FifoAw'(1);
      if (pop)  rptr_q <= rptr_q + FifoAw'(1);
      if (push && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (!push && pop) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  // Tick counter and sticky compare flag
  logic [15:0] cnt_q, cmp_q, cnt_inc;
  logic        flag_q, tick_wr, clr_wr, match;

  assign tick_wr = wr_req && (addr == AddrTick);
  assign clr_wr  = wr_req && (addr == AddrClr);
  assign cnt_inc = cnt_q + 16'd1;
  // Flag rises on the same edge the counter reaches the compare value; a TICK load overrides.
  assign match   = !tick_wr && (cmp_q != 16'd0) && (cnt_inc == cmp_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      cmp_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      if (tick_wr) begin
        cnt_q <= '0;
        cmp_q <= wdata;
      end else begin
        cnt_q <= cnt_inc;
      end
      if (match) begin
        flag_q <= 1'b1;
      end else if (clr_wr) begin
        flag_q <= 1'b0;
      end
    end
  end

  assign tick_flag = flag_q;

  // Read mux reflects state before any same-edge update.
  always_comb begin
    rd_val = '0;
    if (!addr[15]) begin
      rd_val = ram_q[addr[RamAw-1:0]];
    end else begin
      unique case (addr)
        AddrEvt:    rd_val = empty ? 16'h0000 : {8'h00, fifo_q[rptr_q]};
        AddrStatus: rd_val = {13'b0, flag_q, full, empty};
        AddrTick:   rd_val = cnt_q;
        default:    rd_val = '0;
      endcase
    end
  end

  // Response FSM
  always_comb begin
    state_d = StIdle;
    if (rd_req) state_d = StResp;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (rd_req) rdata_q <= rd_val;
    end
  end

  assign rvalid = (state_q == StResp);
  assign rdata  = rdata_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Scoreboard bench for mem_io_responder: read expectations are queued when a request is
// driven and compared when rvalid pulses; side-band outputs are checked directly.
module tb_mem_io_responder;

  logic        clk = 1'b0;
  logic        reset, memread, memwrite, evt_valid;
  logic [15:0] addr, wdata, rdata;
  logic        rvalid, evt_ready, tick_flag;
  logic [7:0]  evt_data;

  mem_io_responder #(
    .RAM_DEPTH  (1024),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .memread   (memread),
    .memwrite  (memwrite),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .evt_valid (evt_valid),
    .evt_data  (evt_data),
    .evt_ready (evt_ready),
    .tick_flag (tick_flag)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [15:0] exp_q [$];
  string       tag_q [$];
  logic [7:0]  fifo_m [$];
  string       mon_tag;
  logic [15:0] mon_exp;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, got, exp);
    end
  endtask

  // Response monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (rvalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_rvalid", 16'd1, 16'd0);
      end else begin
        mon_tag = tag_q.pop_front();
        mon_exp = exp_q.pop_front();
        check(mon_tag, rdata, mon_exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    memread  = 1'b0;
    memwrite = 1'b1;
    addr     = a;
    wdata    = d;
    tick();
    memwrite = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, input logic [15:0] e, input string t);
    memread  = 1'b1;
    memwrite = 1'b0;
    addr     = a;
    exp_q.push_back(e);
    tag_q.push_back(t);
    tick();
    memread = 1'b0;
  endtask

  task automatic rd_evt(input string t);
    logic [15:0] e;
    if (fifo_m.size() > 0) e = {8'h00, fifo_m.pop_front()};
    else e = 16'h0000;
    rd(16'hFF00, e, t);
  endtask

  task automatic push_evt(input logic [7:0] d);
    logic rdy;
    rdy = (fifo_m.size() < 4);
    check("evt_ready_pre_push", 16'(evt_ready), 16'(rdy));
    evt_valid = 1'b1;
    evt_data  = d;
    tick();
    evt_valid = 1'b0;
    if (rdy) fifo_m.push_back(d);
  endtask

  function automatic logic [15:0] status_exp(input logic f);
    return {13'b0, f, fifo_m.size() == 4, fifo_m.size() == 0};
  endfunction

  initial begin
    reset = 1'b1; memread = 1'b0; memwrite = 1'b0; addr = '0; wdata = '0;
    evt_valid = 1'b0; evt_data = '0;
    tick();
    tick();
    check("reset_rvalid", 16'(rvalid), 16'd0);
    check("reset_rdata", rdata, 16'h0000);
    check("reset_evt_ready", 16'(evt_ready), 16'd0);
    check("reset_tick_flag", 16'(tick_flag), 16'd0);
    reset = 1'b0;
    #1;
    check("release_evt_ready", 16'(evt_ready), 16'd1);
    tick();
    check("release_rvalid", 16'(rvalid), 16'd0);
    check("release_rdata", rdata, 16'h0000);

    // RAM write/read, alias and hold
    wr(16'h0005, 16'hBEEF);
    rd(16'h0005, 16'hBEEF, "ram_rd");
    rd(16'h0405, 16'hBEEF, "ram_alias");
    tick();
    check("rdata_hold", rdata, 16'hBEEF);
    check("rvalid_idle", 16'(rvalid), 16'd0);
    wr(16'h0000, 16'h0F0F);
    wr(16'h9000, 16'h1234);
    rd(16'h0000, 16'h0F0F, "ram_no_io_alias");
    rd(16'h9000, 16'h0000, "unmapped_rd");
    rd(16'hFF03, 16'h0000, "clr_rd");
    rd(16'hFF10, 16'h0000, "unmapped_io_rd");

    // FIFO fill, hold-off, drain
    push_evt(8'h11);
    push_evt(8'h22);
    push_evt(8'h33);
    push_evt(8'h44);
    check("fifo_full_ready", 16'(evt_ready), 16'd0);
    rd(16'hFF01, status_exp(1'b0), "status_full");
    push_evt(8'h55);
    for (int i = 0; i < 4; i++) rd_evt("evt_drain");
    rd_evt("evt_empty");
    rd(16'hFF01, status_exp(1'b0), "status_empty");

    // Simultaneous push/pop on non-empty and on empty FIFO
    push_evt(8'h66);
    push_evt(8'h77);
    evt_valid = 1'b1; evt_data = 8'h88;
    rd_evt("evt_pushpop_oldest");
    evt_valid = 1'b0;
    fifo_m.push_back(8'h88);
    rd(16'hFF01, status_exp(1'b0), "status_count2");
    rd_evt("evt_after_pushpop");
    rd_evt("evt_after_pushpop");
    rd(16'hFF01, status_exp(1'b0), "status_empty2");
    evt_valid = 1'b1; evt_data = 8'h99;
    rd_evt("evt_pushpop_empty");
    evt_valid = 1'b0;
    fifo_m.push_back(8'h99);
    rd_evt("evt_push_landed");

    // Read+write together: write wins, no response, no pop
    push_evt(8'hAB);
    memread = 1'b1; memwrite = 1'b1; addr = 16'hFF00; wdata = 16'h0000;
    tick();
    memread = 1'b0; memwrite = 1'b0;
    tick();
    rd_evt("evt_not_popped");
    rd(16'hFF01, status_exp(1'b0), "status_after_rw");

    // Tick counter read and flag timing
    wr(16'hFF02, 16'h0000);
    tick(); tick(); tick();
    rd(16'hFF02, 16'h0003, "tick_rd");
    wr(16'hFF02, 16'h0010);
    for (int i = 1; i <= 16; i++) begin
      tick();
      check("tick_flag_rise", 16'(tick_flag), 16'(i == 16));
    end
    tick(); tick();
    check("tick_flag_sticky", 16'(tick_flag), 16'd1);
    rd(16'hFF01, status_exp(1'b1), "status_flag");
    wr(16'hFF03, 16'h0001);
    check("tick_flag_clr", 16'(tick_flag), 16'd0);

    // CLR in the match cycle: set wins
    wr(16'hFF02, 16'h0010);
    for (int i = 0; i < 15; i++) tick();
    check("tick_flag_pre_match", 16'(tick_flag), 16'd0);
    wr(16'hFF03, 16'h0000);
    check("tick_flag_clr_vs_match", 16'(tick_flag), 16'd1);

    // TICK write in the match cycle: load wins
    wr(16'hFF03, 16'h0000);
    check("tick_flag_clr2", 16'(tick_flag), 16'd0);
    wr(16'hFF02, 16'h0005);
    for (int i = 0; i < 4; i++) tick();
    wr(16'hFF02, 16'h0008);
    check("tick_flag_load_vs_match", 16'(tick_flag), 16'd0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("tick_flag_reload", 16'(tick_flag), 16'(i == 8));
    end

    // Reset during a response cycle
    push_evt(8'h01);
    push_evt(8'h02);
    rd(16'h0005, 16'hBEEF, "ram_before_reset");
    reset = 1'b1; memread = 1'b1; addr = 16'hFF00;
    tick();
    check("midreset_rvalid", 16'(rvalid), 16'd0);
    check("midreset_rdata", rdata, 16'h0000);
    check("midreset_evt_ready", 16'(evt_ready), 16'd0);
    reset = 1'b0; memread = 1'b0;
    fifo_m.delete();
    #1;
    check("postreset_evt_ready", 16'(evt_ready), 16'd1);
    check("postreset_rvalid", 16'(rvalid), 16'd0);
    check("postreset_rdata", rdata, 16'h0000);
    check("postreset_tick_flag", 16'(tick_flag), 16'd0);
    rd(16'hFF01, status_exp(1'b0), "postreset_status");
    rd(16'hFF02, 16'h0001, "postreset_counter");
    tick();
    tick();
    check("sb_drain", 16'(exp_q.size()), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_io_responder.md
# mem_io_responder

Memory-side responder for the multicycle CPU's memread/memwrite bus. Serves CPU loads, stores and instruction fetches from an internal word RAM and a small memory-mapped I/O page. The I/O page holds:
- an input-event FIFO (game controller events);
- a free-running tick counter with a sticky compare flag.

It sits between the control/datapath and the game peripherals, and returns read data one cycle after each request.

## Interface
- RAM_DEPTH, 1024, words of internal RAM (power of two, ≤ 32768)
- FIFO_DEPTH, 4, event FIFO entries (power of two, ≥ 2)
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- memread  in  1  read request, sampled each rising edge
- memwrite  in  1  write request, sampled each rising edge
- addr  in  16  word address
- wdata  in  16  write data
- rdata  out  16  read data, registered
- rvalid  out  1  one-cycle pulse: rdata holds response to previous-cycle read
- evt_valid  in  1  peripheral event offered
- evt_data  in  8  event code
- evt_ready  out  1  FIFO can accept (not full and not in reset)
- tick_flag  out  1  sticky compare-match flag (also readable at STATUS)

## Operation
- Address map:
  - addr[15]==0: RAM, index = addr mod RAM_DEPTH.
  - 0xFF00 EVT: read pops the FIFO and returns {8'h00, head}; returns 0x0000 with no pop when empty. Write ignored.
  - 0xFF01 STATUS (read-only): {13'b0, tick_flag, full, empty}.
  - 0xFF02 TICK: read returns counter; write loads compare and clears counter to 0.
  - 0xFF03 CLR: any write clears tick_flag; read returns 0x0000.
  - All other addresses ≥0x8000: read 0x0000, write ignored.
- Response FSM has two states:
  - IDLE → RESP when memread && !memwrite.
  - RESP → RESP on a further read, else → IDLE.
  - rvalid=1 exactly while in RESP.
- memread and memwrite together: the write is performed and the read is dropped (no rvalid, no FIFO pop).
- Write semantics: a RAM write lands at the clock edge. A read of the same address next cycle returns the new data.
- FIFO:
  - Push when evt_valid && evt_ready. evt_ready = !full and is not relieved by a same-cycle pop.
  - Pop only on an accepted EVT read with the FIFO non-empty.
  - Push and pop in the same cycle on a non-empty FIFO: count unchanged, order preserved.
  - Push and pop in the same cycle on an empty FIFO: the read returns 0x0000 and the push lands.
  - Pointers wrap mod FIFO_DEPTH. Count width is log2(FIFO_DEPTH)+1.
- Tick counter:
  - 16-bit, +1 every cycle, wraps 0xFFFF→0x0000.
  - tick_flag sets when counter==compare and compare≠0, and stays set until cleared.
  - A CLR write in the same cycle as a match leaves the flag set (set wins).
  - A TICK write in the cycle of a match: the new compare and the counter clear win, and the flag is not set that cycle.

## Timing
- Read latency is 1 cycle: request at edge N, rdata/rvalid valid after edge N+1.
- Back-to-back reads every cycle are supported, with one response per request.
- rdata holds its last value when rvalid=0.
- Write latency is 0: the write is visible to any read request issued the following cycle.
- A STATUS read reflects state before any same-cycle push/pop.
- A TICK read returns the counter value at the request edge.
- Reset values (while reset=1, and the cycle after release):
  - rdata=0x0000, rvalid=0, FSM=IDLE.
  - FIFO empty, evt_ready=0 during reset and 1 after release.
  - counter=0, compare=0, tick_flag=0.
  - RAM contents are not reset.
- Reset asserted mid-read: the pending response is discarded (rvalid=0 the next cycle) and the FIFO is flushed.

## Test plan
- Write 0xBEEF to 0x0005, then read 0x0005 the next cycle → rvalid pulse with rdata=0xBEEF. Reading 0x0405 with RAM_DEPTH=1024 also returns 0xBEEF (alias).
- Push events 0x11,0x22,0x33,0x44 → evt_ready=0 and STATUS=0x0002. A 5th event is held off. Four EVT reads return 0x0011..0x0044 in order. A 5th EVT read returns 0x0000, then STATUS=0x0001.
- Hold FIFO at count 2, then do an EVT read and a push in the same cycle → count stays 2 and the read returns the oldest entry.
- Write 0x0010 to TICK → tick_flag rises exactly 16 cycles later and stays set. A CLR write clears it. CLR and match in the same cycle leaves tick_flag=1.
- memread=memwrite=1 at 0xFF00 with FIFO non-empty → no rvalid, FIFO count unchanged.
- Assert reset for 1 cycle during a RESP cycle → rvalid=0, rdata=0x0000, FIFO empty, counter=0, tick_flag=0, evt_ready=1 the cycle after release.
